// File: rtl/lsu_pkg.sv
// lsu_pkg: dm access type codes, controller state encoding and access-size helper
package lsu_pkg;
  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  function automatic logic [1:0] dm_last_off(input logic [2:0] t);
    return (t == DM_WORD) ? 2'd3 : (t == DM_HALF || t == DM_HALF_U) ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/lsu_req_chk.sv
// lsu_req_chk: combinational legality check of a load/store request
//   i_we   : 1=store, 0=load
//   i_addr : byte address
//   i_type : dm access type
//   o_err  : request is misaligned, out of range or uses an illegal type
module lsu_req_chk import lsu_pkg::*; #(
  parameter int ADDR_W = 6
) (
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_type,
  output logic              o_err
);
  logic [ADDR_W:0] w_last;
  logic            w_bad_type;
  logic            w_misalign;
  // carry out of the last-byte address means the access runs past the top of dm
  assign w_last     = {1'b0, i_addr} + {{(ADDR_W-1){1'b0}}, dm_last_off(i_type)};
  assign w_bad_type = (i_type > DM_BYTE_U) || (i_we && (i_type == DM_HALF_U || i_type == DM_BYTE_U));
  assign w_misalign = (i_type == DM_WORD && i_addr[1:0] != 2'b00) ||
                      ((i_type == DM_HALF || i_type == DM_HALF_U) && i_addr[0]);
  assign o_err      = w_bad_type | w_misalign | w_last[ADDR_W];
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store controller in front of the data memory
//   clk/rstn            : clock, asynchronous active-low reset
//   req_*               : one request at a time (valid/ready), we/addr/type/wdata
//   resp_*              : held response with load data and error flag
//   dm_*                : data memory port (write enable, addr, write data, type, read data)
//   cnt_load/store/err  : saturating completed-access counters
module lsu_mem_ctrl import lsu_pkg::*; #(
  parameter int ADDR_W = 6,
  parameter int DM_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_type,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              dm_wr,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic [2:0]        dm_type,
  input  logic [31:0]       dm_dout,
  output logic [CNT_W-1:0]  cnt_load,
  output logic [CNT_W-1:0]  cnt_store,
  output logic [CNT_W-1:0]  cnt_err
);
  localparam int WC_W = $clog2(DM_LAT + 1) + 1;
  state_t            r_state, w_next;
  logic              r_we, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_type;
  logic [31:0]       r_wdata, r_rdata;
  logic [WC_W-1:0]   r_wcnt;
  logic [CNT_W-1:0]  r_cnt_load, r_cnt_store, r_cnt_err;
  logic              w_err, w_acc, w_done, w_wait_end;
  lsu_req_chk #(.ADDR_W(ADDR_W)) u_chk (
    .i_we   (req_we),
    .i_addr (req_addr),
    .i_type (req_type),
    .o_err  (w_err)
  );
  assign w_acc      = (r_state == IDLE) && req_valid;
  assign w_done     = (r_state == RESP) && resp_ready;
  assign w_wait_end = (r_state == WAIT) && (r_wcnt == WC_W'(DM_LAT));
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next = (r_state == IDLE)  ? (req_valid ? (w_err ? RESP : ISSUE) : IDLE) :
             (r_state == ISSUE) ? WAIT :
             (r_state == WAIT)  ? (w_wait_end ? RESP : WAIT) :
                                  (resp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_type      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_wcnt      <= '0;
      r_cnt_load  <= '0;
      r_cnt_store <= '0;
      r_cnt_err   <= '0;
    end else begin
      if (w_acc) begin
        r_we    <= req_we;
        r_err   <= w_err;
        r_addr  <= req_addr;
        r_type  <= req_type;
        r_wdata <= req_wdata;
        r_rdata <= '0;
      end
      // wait counter starts at 1 on the issue edge so it equals DM_LAT when dm_dout is valid
      r_wcnt <= (r_state == ISSUE) ? WC_W'(1) : (r_state == WAIT) ? r_wcnt + WC_W'(1) : r_wcnt;
      if (w_wait_end && !r_we) r_rdata <= dm_dout;
      if (w_done && r_err && !(&r_cnt_err)) r_cnt_err <= r_cnt_err + CNT_W'(1);
      if (w_done && !r_err && r_we && !(&r_cnt_store)) r_cnt_store <= r_cnt_store + CNT_W'(1);
      if (w_done && !r_err && !r_we && !(&r_cnt_load)) r_cnt_load <= r_cnt_load + CNT_W'(1);
    end
  end
  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = resp_valid ? r_rdata : 32'h0;
  assign resp_err   = resp_valid & r_err;
  assign dm_wr      = (r_state == ISSUE) & r_we;
  assign dm_addr    = r_addr;
  assign dm_din     = r_wdata;
  assign dm_type    = r_type;
  assign cnt_load   = r_cnt_load;
  assign cnt_store  = r_cnt_store;
  assign cnt_err    = r_cnt_err;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed self-checking bench for lsu_mem_ctrl with a byte-array dm model
module tb_lsu_mem_ctrl;
  logic        clk, rstn;
  logic        req_valid, req_ready, req_we;
  logic [5:0]  req_addr;
  logic [2:0]  req_type;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        dm_wr;
  logic [5:0]  dm_addr;
  logic [31:0] dm_din, dm_dout;
  logic [2:0]  dm_type;
  logic [15:0] cnt_load, cnt_store, cnt_err;
  logic        s_req_ready, s_resp_valid, s_resp_err, s_dm_wr;
  logic [31:0] s_resp_rdata, s_dm_din;
  logic [5:0]  s_dm_addr;
  logic [2:0]  s_dm_type;
  logic [1:0]  s_cnt_load, s_cnt_store, s_cnt_err;
  logic [7:0]  mem [64];
  logic [5:0]  m1, m2, m3;
  int          total = 0;
  int          bad = 0;
  lsu_mem_ctrl #(.ADDR_W(6), .DM_LAT(1), .CNT_W(16)) u_dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .dm_wr(dm_wr),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_type(dm_type), .dm_dout(dm_dout),
    .cnt_load(cnt_load), .cnt_store(cnt_store), .cnt_err(cnt_err)
  );
  // narrow-counter twin sharing the same stimulus, used to reach saturation quickly
  lsu_mem_ctrl #(.ADDR_W(6), .DM_LAT(1), .CNT_W(2)) u_sat (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(s_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata), .resp_valid(s_resp_valid),
    .resp_ready(resp_ready), .resp_rdata(s_resp_rdata), .resp_err(s_resp_err), .dm_wr(s_dm_wr),
    .dm_addr(s_dm_addr), .dm_din(s_dm_din), .dm_type(s_dm_type), .dm_dout(dm_dout),
    .cnt_load(s_cnt_load), .cnt_store(s_cnt_store), .cnt_err(s_cnt_err)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  assign m1 = dm_addr + 6'd1;
  assign m2 = dm_addr + 6'd2;
  assign m3 = dm_addr + 6'd3;
  function automatic logic [31:0] dm_rd(input logic [5:0] a, input logic [2:0] t);
    logic [7:0] b0, b1, b2, b3;
    logic [5:0] a1, a2, a3;
    a1 = a + 6'd1;
    a2 = a + 6'd2;
    a3 = a + 6'd3;
    b0 = mem[a];
    b1 = mem[a1];
    b2 = mem[a2];
    b3 = mem[a3];
    case (t)
      3'b000:  return {b3, b2, b1, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b010:  return {16'h0, b1, b0};
      3'b011:  return {{24{b0[7]}}, b0};
      default: return {24'h0, b0};
    endcase
  endfunction
  always @(posedge clk) begin
    if (dm_wr) begin
      mem[dm_addr] <= dm_din[7:0];
      if (dm_type == 3'b000 || dm_type == 3'b001) mem[m1] <= dm_din[15:8];
      if (dm_type == 3'b000) begin
        mem[m2] <= dm_din[23:16];
        mem[m3] <= dm_din[31:24];
      end
    end
    dm_dout <= dm_rd(dm_addr, dm_type);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic we, input logic [5:0] a, input logic [2:0] t,
                     input logic [31:0] wd, input logic [31:0] erd, input logic eer,
                     input int elat, input int ewr);
    int lat, wrc;
    logic [31:0] rd;
    logic er;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_type  = t;
    req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wrc = 0;
    for (lat = 1; lat < 20; lat++) begin
      wrc += int'(dm_wr);
      if (resp_valid) break;
      @(negedge clk);
    end
    rd = resp_rdata;
    er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_rdata"}, rd, erd);
    chk({tag, "_err"}, 32'(er), 32'(eer));
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_dmwr"}, 32'(wrc), 32'(ewr));
  endtask
  initial begin
    int n;
    rstn = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_type = '0;
    req_wdata = '0;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_dm_wr", 32'(dm_wr), 0);
    chk("rst_dm_addr", 32'(dm_addr), 0);
    chk("rst_cnt_load", 32'(cnt_load), 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    run("st_word",   1'b1, 6'h04, 3'b000, 32'hDEADBEEF, 32'h0,        1'b0, 3, 1);
    run("ld_word",   1'b0, 6'h04, 3'b000, 32'h0,        32'hDEADBEEF, 1'b0, 3, 0);
    run("st_byte",   1'b1, 6'h09, 3'b011, 32'h12345680, 32'h0,        1'b0, 3, 1);
    run("ld_byte",   1'b0, 6'h09, 3'b011, 32'h0,        32'hFFFFFF80, 1'b0, 3, 0);
    run("ld_byte_u", 1'b0, 6'h09, 3'b100, 32'h0,        32'h00000080, 1'b0, 3, 0);
    run("ld_half_mis", 1'b0, 6'h03, 3'b001, 32'h0,        32'h0, 1'b1, 1, 0);
    chk("cnt_err_1", 32'(cnt_err), 1);
    run("ld_word_mis", 1'b0, 6'h06, 3'b000, 32'h0,        32'h0, 1'b1, 1, 0);
    chk("cnt_err_2", 32'(cnt_err), 2);
    run("st_byte_u",   1'b1, 6'h08, 3'b100, 32'h55555555, 32'h0, 1'b1, 1, 0);
    chk("cnt_err_3", 32'(cnt_err), 3);
    chk("mem_after_err", dm_rd(6'h08, 3'b100), 32'h0);
    // held response, with a competing request waiting behind it
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 6'h04;
    req_type = 3'b000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_lat", 32'(n), 2);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 6'h10;
    req_wdata = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(resp_valid), 1);
      chk("hold_rdata", resp_rdata, 32'hDEADBEEF);
      chk("hold_req_ready", 32'(req_ready), 0);
      chk("hold_dm_wr", 32'(dm_wr), 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("ack_resp_valid", 32'(resp_valid), 0);
    chk("ack_req_ready", 32'(req_ready), 1);
    chk("ack_dm_wr", 32'(dm_wr), 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("queued_issue_wr", 32'(dm_wr), 1);
    chk("queued_issue_din", dm_din, 32'h11111111);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("cnt_load_4", 32'(cnt_load), 4);
    chk("cnt_store_3", 32'(cnt_store), 3);
    chk("cnt_err_3b", 32'(cnt_err), 3);
    chk("mem_queued_store", dm_rd(6'h10, 3'b000), 32'h11111111);
    // asynchronous reset while a store waits on dm
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 6'h20;
    req_type = 3'b000;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rw_issue_wr", 32'(dm_wr), 1);
    @(negedge clk);
    chk("rw_wait_wr", 32'(dm_wr), 0);
    chk("rw_wait_addr", 32'(dm_addr), 32'h20);
    rstn = 1'b0;
    #1;
    chk("rw_dm_addr", 32'(dm_addr), 0);
    chk("rw_dm_din", dm_din, 0);
    chk("rw_resp_valid", 32'(resp_valid), 0);
    chk("rw_cnt_store", 32'(cnt_store), 0);
    chk("rw_cnt_err", 32'(cnt_err), 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("rw_no_resp", 32'(resp_valid), 0);
    chk("rw_ready", 32'(req_ready), 1);
    chk("rw_cnt_load", 32'(cnt_load), 0);
    // saturation on the 2-bit twin
    for (int i = 0; i < 3; i++)
      run("sat_ld", 1'b0, 6'h04, 3'b000, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);
    chk("sat_cnt_3", 32'(s_cnt_load), 3);
    run("sat_ld4", 1'b0, 6'h04, 3'b000, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);
    chk("sat_cnt_hold", 32'(s_cnt_load), 3);
    chk("main_cnt_4", 32'(cnt_load), 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
